// File: rtl/perf_counter_reader.sv
// perf_counter_reader: snapshots four 19-bit performance counters when req is
// seen in IDLE. It then streams a 14-byte frame over a valid/ready byte
// interface. The frame is a 0xA5 header, then four 24-bit big-endian counter
// fields, then an XOR checksum of the first 13 bytes.
module perf_counter_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] instruction_count,
  input  logic [18:0] aritmetric_count,
  input  logic [18:0] memory_count,
  input  logic [18:0] stall_count,
  input  logic        req,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  frames_sent
);

  localparam logic [7:0] HEADER   = 8'hA5;
  localparam logic [3:0] LAST_IDX = 4'd13;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  frames_q, frames_d;
  logic        load_snap;
  logic [18:0] cnt_in [4];
  logic [18:0] snap_q [4];
  logic [7:0]  frame_bytes [13];
  logic [7:0]  csum;
  logic [7:0]  cur_byte;

  assign cnt_in[0] = instruction_count;
  assign cnt_in[1] = aritmetric_count;
  assign cnt_in[2] = memory_count;
  assign cnt_in[3] = stall_count;

  assign frame_bytes[0] = HEADER;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_counter
      // Snapshot register: captured only on the edge that accepts a request.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          snap_q[gi] <= '0;
        end else if (load_snap) begin
          snap_q[gi] <= cnt_in[gi];
        end
      end

      // Zero-extend to 24 bits and send MSB byte first.
      assign frame_bytes[1 + 3*gi] = {5'b00000, snap_q[gi][18:16]};
      assign frame_bytes[2 + 3*gi] = snap_q[gi][15:8];
      assign frame_bytes[3 + 3*gi] = snap_q[gi][7:0];
    end
  endgenerate

  // Checksum is the XOR of every byte before it in the frame.
  always_comb begin
    csum = 8'h00;
    for (int k = 0; k < 13; k++) begin
      csum = csum ^ frame_bytes[k];
    end
  end

  // Select the byte for the current index; index 13 carries the checksum.
  always_comb begin
    cur_byte = csum;
    if (idx_q < LAST_IDX) begin
      cur_byte = frame_bytes[idx_q];
    end
  end

  assign out_valid   = (state_q == SEND);
  assign busy        = out_valid;
  assign out_last    = out_valid && (idx_q == LAST_IDX);
  assign out_data    = out_valid ? cur_byte : 8'h00;
  assign frames_sent = frames_q;

  // Next-state logic. Requests are ignored while SEND is active.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frames_d  = frames_q;
    load_snap = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d   = SEND;
          idx_d     = 4'd0;
          load_snap = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d  = IDLE;
            idx_d    = 4'd0;
            frames_d = frames_q + 8'd1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // State, index and frame counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      frames_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Testbench for perf_counter_reader. A behavioural frame model is built from
// the counter values, and each received frame is compared against it.
module tb_perf_counter_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] ic, ac, mc, sc;
  logic        req, out_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy;
  logic [7:0]  frames_sent;

  int tests = 0;
  int fails = 0;
  int exp_frames = 0;

  logic [7:0] exp_b [14];
  logic [7:0] got_data [14];
  logic       got_last [14];
  int         got_n, stall_viol, drops;
  bit         timeout;

  perf_counter_reader dut (
    .clk(clk), .rst(rst),
    .instruction_count(ic), .aritmetric_count(ac),
    .memory_count(mc), .stall_count(sc),
    .req(req), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  // Reference frame: header, four zero-extended 24-bit big-endian fields, XOR.
  function automatic void model_frame(input logic [18:0] i_c, a_c, m_c, s_c);
    logic [23:0] c [4];
    logic [7:0]  x;
    c[0] = {5'd0, i_c}; c[1] = {5'd0, a_c}; c[2] = {5'd0, m_c}; c[3] = {5'd0, s_c};
    exp_b[0] = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      exp_b[1 + 3*k] = 8'((c[k] >> 16) & 24'hFF);
      exp_b[2 + 3*k] = 8'((c[k] >> 8) & 24'hFF);
      exp_b[3 + 3*k] = 8'(c[k] & 24'hFF);
    end
    x = 8'h00;
    for (int k = 0; k < 13; k++) x = x ^ exp_b[k];
    exp_b[13] = x;
  endfunction

  task automatic send_req(input logic [18:0] i_c, a_c, m_c, s_c);
    @(negedge clk);
    ic = i_c; ac = a_c; mc = m_c; sc = s_c;
    req = 1'b1;
    model_frame(i_c, a_c, m_c, s_c);
  endtask

  // Gather nbytes transfers, tracking stalled-cycle stability and valid drops.
  // With disturb set, counters are changed and req is held high mid-frame.
  task automatic collect(input int nbytes, input bit rand_ready, input bit disturb);
    bit         pv, pr, pl;
    logic [7:0] pd;
    int         cyc;
    got_n = 0; stall_viol = 0; drops = 0; timeout = 0;
    pv = 0; pr = 0; pd = 8'h00; pl = 0; cyc = 0;
    while (got_n < nbytes) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin timeout = 1; break; end
      if (pv && !pr && (out_data !== pd || out_last !== pl || out_valid !== 1'b1))
        stall_viol++;
      if (out_valid !== 1'b1) drops++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_data[got_n] = out_data;
        got_last[got_n] = out_last;
        got_n++;
      end
      pv = out_valid; pd = out_data; pl = out_last;
      if (disturb) begin
        ic = 19'h12345; ac = 19'h12345; mc = 19'h12345; sc = 19'h12345;
        req = 1'b1;
      end else begin
        req = 1'b0;
      end
      if (got_n < nbytes) out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      else                out_ready = 1'b1;
      pr = out_ready;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b1; out_ready = 1'b1;
    ic = 19'h1; ac = 19'h2; mc = 19'h3; sc = 19'h4;
    repeat (3) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
        out_data !== 8'h00 || frames_sent !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: valid=%b busy=%b last=%b data=%h frames=%h, required 0 0 0 00 00",
               out_valid, busy, out_last, out_data, frames_sent);
    end
    rst = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL req_during_reset: out_valid=%b, required 0", out_valid);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic;
    logic [7:0] lit [14];
    int bad;
    lit = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h0C,
            8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'hBB};
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_pre_valid: out_valid=%b, required 0", out_valid);
    end
    send_req(19'h00010, 19'h0000C, 19'h00003, 19'h00001);
    collect(14, 0, 0);
    bad = -1;
    for (int i = 0; i < 14; i++)
      if (got_data[i] !== lit[i] || got_last[i] !== (i == 13)) begin bad = i; break; end
    tests++;
    if (timeout || got_n != 14 || bad >= 0) begin
      fails++;
      $display("FAIL basic_frame: idx=%0d got=%h last=%b, required %h (n=%0d)",
               bad, got_data[bad < 0 ? 0 : bad], got_last[bad < 0 ? 0 : bad],
               lit[bad < 0 ? 0 : bad], got_n);
    end
    tests++;
    if (drops != 0) begin
      fails++;
      $display("FAIL basic_consecutive: valid dropped %0d times, required 0", drops);
    end
    @(negedge clk);
    exp_frames = (exp_frames + 1) % 256;
    tests++;
    if (out_valid !== 1'b0 || frames_sent !== 8'(exp_frames)) begin
      fails++;
      $display("FAIL basic_end: valid=%b frames=%0d, required 0 %0d", out_valid, frames_sent, exp_frames);
    end
    $display("[TB] test_basic frame received %0d bytes", got_n);
  endtask

  task automatic run_checked(input string name, input logic [18:0] i_c, a_c, m_c, s_c,
                             input bit rand_ready, input bit disturb);
    int bad;
    send_req(i_c, a_c, m_c, s_c);
    collect(14, rand_ready, disturb);
    bad = -1;
    for (int i = 0; i < 14; i++)
      if (got_data[i] !== exp_b[i] || got_last[i] !== (i == 13)) begin bad = i; break; end
    tests++;
    if (timeout || got_n != 14 || bad >= 0 || stall_viol != 0 || drops != 0) begin
      fails++;
      $display("FAIL %s: idx=%0d got=%h required %h n=%0d stall_viol=%0d drops=%0d timeout=%0b",
               name, bad, got_data[bad < 0 ? 0 : bad], exp_b[bad < 0 ? 0 : bad],
               got_n, stall_viol, drops, timeout);
    end
    @(negedge clk);
    req = 1'b0;
    exp_frames = (exp_frames + 1) % 256;
    tests++;
    if (out_valid !== 1'b0 || frames_sent !== 8'(exp_frames)) begin
      fails++;
      $display("FAIL %s_end: valid=%b frames=%0d, required 0 %0d",
               name, out_valid, frames_sent, exp_frames);
    end
  endtask

  task automatic test_max;
    run_checked("max_frame", 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 0, 0);
    tests++;
    if (got_data[13] !== 8'hA5 || got_data[1] !== 8'h07) begin
      fails++;
      $display("FAIL max_values: checksum=%h top=%h, required A5 07", got_data[13], got_data[1]);
    end
    $display("[TB] test_max checksum %h", got_data[13]);
  endtask

  task automatic test_backpressure;
    for (int r = 0; r < 3; r++)
      run_checked("backpressure", 19'h00010, 19'h0000C, 19'h00003, 19'h00001, 1, 0);
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_snapshot;
    run_checked("snapshot", 19'h0ABCD, 19'h00F0F, 19'h70001, 19'h00042, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || frames_sent !== 8'(exp_frames)) begin
        fails++;
        $display("FAIL snapshot_not_queued: valid=%b frames=%0d, required 0 %0d",
                 out_valid, frames_sent, exp_frames);
      end
    end
    $display("[TB] test_snapshot done");
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++)
      run_checked("random_frame", 19'($urandom), 19'($urandom), 19'($urandom),
                  19'($urandom), 1, 0);
    $display("[TB] test_random done");
  endtask

  task automatic test_reset_midframe;
    send_req(19'($urandom), 19'($urandom), 19'($urandom), 19'($urandom));
    collect(6, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frames_sent !== 8'h00 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: valid=%b busy=%b frames=%0d data=%h, required 0 0 0 00",
               out_valid, busy, frames_sent, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: out_valid=%b, required 0", out_valid);
    end
    run_checked("after_reset", 19'($urandom), 19'($urandom), 19'($urandom), 19'($urandom), 0, 0);
    $display("[TB] test_reset_midframe done");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    exp_frames = 0;
    for (int f = 0; f < 256; f++)
      run_checked("b2b_frame", 19'($urandom), 19'($urandom), 19'($urandom),
                  19'($urandom), 0, 0);
    tests++;
    if (frames_sent !== 8'h00) begin
      fails++;
      $display("FAIL frames_wrap: frames_sent=%0d, required 0", frames_sent);
    end
    $display("[TB] test_back_to_back frames_sent=%0d", frames_sent);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; out_ready = 1'b0;
    ic = '0; ac = '0; mc = '0; sc = '0;
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_snapshot();
    test_random();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
